// File: rtl/ram_burst_pkg.sv
// Shared types and default widths for the RAM burst master.
package ram_burst_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, upstream write stream, downstream read stream and RAM port bundle.
interface ram_burst_master_if
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              cmd_start;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  // Controller side.
  modport master (
    input  cmd_start, cmd_wr, cmd_addr, cmd_len,
    output busy, done,
    input  wr_data, wr_valid,
    output wr_ready,
    output rd_data, rd_valid,
    input  rd_ready,
    output mem_addr, mem_wdata, mem_wr,
    input  mem_rdata
  );

  // Surrounding logic / RAM side.
  modport slave (
    output cmd_start, cmd_wr, cmd_addr, cmd_len,
    input  busy, done,
    output wr_data, wr_valid,
    input  wr_ready,
    input  rd_data, rd_valid,
    output rd_ready,
    input  mem_addr, mem_wdata, mem_wr,
    output mem_rdata
  );

endinterface

// File: rtl/ram_burst_master.sv
// Burst controller for the single-port RAM: streams write beats into the RAM
// or reads a range back out through a registered, backpressured read port.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  ram_burst_master_if.master  bus
);

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] count_q,    count_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_capture;

  // A read capture happens whenever the output register is empty or being drained.
  assign rd_capture = !rd_valid_q || bus.rd_ready;

  // State register and burst bookkeeping; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state logic: count holds remaining beats minus one, address wraps naturally.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_start) begin
          cur_addr_d = bus.cmd_addr;
          count_d    = bus.cmd_len;
          rd_valid_d = 1'b0;
          state_d    = bus.cmd_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        if (bus.wr_valid) begin
          cur_addr_d = cur_addr_q + 1'b1;
          if (count_q == '0) state_d = DONE;
          else               count_d = count_q - 1'b1;
        end
      end
      READ: begin
        if (rd_capture) begin
          rd_data_d  = bus.mem_rdata;
          rd_valid_d = 1'b1;
          cur_addr_d = cur_addr_q + 1'b1;
          if (count_q == '0) state_d = DRAIN;
          else               count_d = count_q - 1'b1;
        end
      end
      DRAIN: begin
        if (rd_valid_q && bus.rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: RAM port is only driven during active transfer states, zero otherwise.
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.busy = 1'b0;
      end
      WRITE: begin
        bus.busy      = 1'b1;
        bus.wr_ready  = 1'b1;
        bus.mem_addr  = cur_addr_q;
        bus.mem_wdata = bus.wr_data;
        bus.mem_wr    = bus.wr_valid;
      end
      READ: begin
        bus.busy     = 1'b1;
        bus.mem_addr = cur_addr_q;
      end
      DRAIN: begin
        bus.busy = 1'b1;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator-side controller for the single-port 8-bit `ram` block. Accepts a burst command (direction, base address, length), then drives `addr`/`wdata`/`wr` to stream data into the RAM or read it back. Upstream write data arrives over a valid/ready handshake, and read data leaves over a valid/ready handshake with backpressure. It sits between the command/datapath logic and the RAM; the RAM's ports connect directly to the `mem_*` ports.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 8, RAM data width
- `clk` in 1 — rising-edge clock
- `reset` in 1 — asynchronous, active-high reset
- `cmd_start` in 1 — command strobe; sampled only in IDLE
- `cmd_wr` in 1 — 1 = write burst, 0 = read burst
- `cmd_addr` in ADDR_W — burst base address
- `cmd_len` in ADDR_W — burst length minus 1 (0 → 1 beat, 255 → 256 beats)
- `busy` out 1 — command in progress
- `done` out 1 — one-cycle pulse when burst completes
- `wr_data` in DATA_W — upstream write data
- `wr_valid` in 1 — upstream data valid
- `wr_ready` out 1 — controller accepts write beat
- `rd_data` out DATA_W — read data
- `rd_valid` out 1 — read data valid
- `rd_ready` in 1 — downstream accepts read beat
- `mem_addr` out ADDR_W — to RAM `addr`
- `mem_wdata` out DATA_W — to RAM `wdata`
- `mem_wr` out 1 — to RAM `wr`
- `mem_rdata` in DATA_W — from RAM `rdata` (combinational read of `mem[addr]`)

## Operation
- States:
  - IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - `cmd_start`=1 latches `cmd_addr`→`cur_addr`, `cmd_len`→`count`, `cmd_wr`.
  - Next state is WRITE (`cmd_wr`=1) or READ (`cmd_wr`=0).
- WRITE:
  - `wr_ready`=1; `mem_wr`=`wr_valid` (combinational); `mem_addr`=`cur_addr`; `mem_wdata`=`wr_data`.
  - On each beat (`wr_valid`&`wr_ready`): `cur_addr`++; if `count`==0 → DONE, else `count`--.
  - `wr_valid`=0 stalls with no RAM write.
- READ:
  - `mem_addr`=`cur_addr`.
  - When `!rd_valid | rd_ready`: register `mem_rdata`→`rd_data`, set `rd_valid`=1, `cur_addr`++.
  - On that capture, if `count`==0 → DRAIN, else `count`--.
  - If `rd_valid`=1 and `rd_ready`=0: hold `rd_data` and `cur_addr`; no capture.
- DRAIN:
  - Wait for `rd_valid`&`rd_ready`, then clear `rd_valid` → DONE.
- DONE:
  - `done`=1 for exactly one cycle → IDLE.
- `busy`=1 in WRITE/READ/DRAIN/DONE; 0 in IDLE.
- Address arithmetic is modulo 2^ADDR_W: 8'hFF+1 → 8'h00. A burst crossing the top of memory wraps silently.
- `cmd_start` while `busy`=1 is ignored; no queuing.
- `mem_wr` is never 1 outside WRITE. `wr_ready` is never 1 outside WRITE.
- In READ, `rd_valid` clears on `rd_ready` when no new capture occurs in the same cycle.
- Reset (any time, including mid-burst): state→IDLE; all outputs 0 (`busy`, `done`, `wr_ready`, `rd_valid`, `rd_data`, `mem_addr`, `mem_wdata`, `mem_wr`). A partial burst is abandoned; RAM contents already written remain.

## Timing
- `cmd_start` sampled at edge E0; `busy`=1 and state active from E0.
- Write: first `wr_ready` in the cycle after E0. The RAM write occurs at the same edge the beat is accepted. Throughput is 1 beat/cycle. N beats with `wr_valid` held high → `done` in cycle N+1 after E0.
- Read: first `rd_valid` rises at E0+1 edge (address presented in cycle after E0, captured at its end). With `rd_ready` held high: 1 beat/cycle, and `done` pulses 1 cycle after the last handshake.
- Backpressure adds exactly one cycle of stall per cycle `rd_ready`=0. Data order and address sequence are preserved.
- `done` is registered and lasts one cycle; IDLE follows, so a new `cmd_start` can be accepted in the cycle after `done`.

## Structure
- Shared package `ram_burst_pkg`: state enum (IDLE, WRITE, READ, DRAIN, DONE) and default ADDR_W/DATA_W constants.
- Single module; no sub-module. The bench instantiates the existing `ram` and connects the `mem_*` ports to it.

## Test plan
- Reset, then write burst addr=8'h01, len=1 (2 beats), data 8'h55, 8'h56, `wr_valid` always high → `mem_wr` high for 2 cycles at addr 1, 2; `done` pulse; RAM[1]=8'h55, RAM[2]=8'h56.
- Read burst addr=8'h01, len=1, `rd_ready`=1 → `rd_data` 8'h55 then 8'h56 on consecutive cycles; `done` 1 cycle after the second beat.
- Read 4 beats with `rd_ready` low for 3 cycles mid-burst → no beat lost or duplicated; `rd_data` held stable while stalled; `mem_wr` stays 0.
- Write addr=8'hFE, len=3, data 8'hA0..8'hA3 → RAM[FE]=A0, RAM[FF]=A1, RAM[00]=A2, RAM[01]=A3 (wrap).
- `cmd_start` pulsed while `busy` → ignored; burst completes unchanged. `wr_valid` gaps → no write on gap cycles.
- Assert `reset` after 2 of 4 write beats → all outputs 0 asynchronously; only first 2 locations written; new command accepted after reset release.
